uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter between NREQ byte-producing requesters. It accepts one byte at a time over a valid/ready handshake and issues a one-cycle start pulse to the transmitter. It then holds the grant until the transmitter reports frame completion, or until a start timeout expires. It sits between the command/status sources and the serial TX path, in the same clock domain as the transmitter's oversampling clock divider.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width per request
- START_TIMEOUT, 64, cycles allowed between tx_start and tx_busy rising before the scheduler aborts
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- req_valid  in  NREQ  per-requester byte-available flag
- req_data  in  NREQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  combinational accept; transfer occurs on the edge where valid and ready are both high
- tx_data  out  DATA_W  registered byte presented to the transmitter
- tx_start  out  1  one-cycle pulse requesting the transmitter to send tx_data
- tx_busy  in  1  transmitter is shifting a frame
- tx_done  in  1  one-cycle pulse at the end of the stop bit
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- active  out  1  high from acceptance until completion or abort
- err_timeout  out  1  one-cycle pulse when START_TIMEOUT expires

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Winner is the first i with req_valid[i], searching upward from rr_ptr and wrapping modulo NREQ.
  - req_ready[winner] is high only in IDLE; all other ready bits are low.
  - On the accepting edge: tx_data <= req_data[winner], grant_id <= winner, active <= 1, next state START.
- START: tx_start is high for exactly this cycle. Clear timeout counter. Next state WAIT_BUSY.
- WAIT_BUSY: the counter increments each cycle.
  - tx_busy=1: go to WAIT_DONE.
  - tx_done=1 (takes priority over tx_busy): treat as completion.
  - Counter reaches START_TIMEOUT-1: pulse err_timeout, go to IDLE.
- WAIT_DONE: stay until tx_done=1, which is completion. tx_busy falling without tx_done is ignored.
- Completion or abort:
  - rr_ptr <= (grant_id+1) mod NREQ, active <= 0, next state IDLE.
  - The requester is never retried automatically. The byte is considered consumed at acceptance.
- rr_ptr wraps from NREQ-1 to 0. A lone requester is served repeatedly.
- req_valid changes outside IDLE have no effect. Requesters hold valid/data until they see ready.

## Timing
- Reset values: state IDLE, rr_ptr 0, tx_data 0, grant_id 0, tx_start 0, active 0, err_timeout 0. req_ready is all-zero during the reset cycle.
- Reset mid-frame aborts at the next edge with no err_timeout pulse. The transmitter is reset by the same signal.
- Accept edge T: tx_start high during T+1, WAIT_BUSY from T+2.
- Minimum request-to-request spacing: tx_done at edge D gives IDLE at D+1. The next accept can occur in that cycle, which is the same cycle as the completion edge's successor.
- Throughput: one frame per (frame length + 3) clocks.
- tx_done and tx_busy sampled high together in WAIT_BUSY: completion.
- err_timeout and tx_start are never high in the same cycle.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE/START/WAIT_BUSY/WAIT_DONE),
  - UART_DATA_W = 8,
  - the default timeout constant, shared with the RX controller.
- Sub-module rr_arbiter:
  - purely combinational;
  - inputs req vector and pointer;
  - outputs one-hot grant, encoded index and any_req;
  - reusable for the RX buffer read side.
- Top level contains the FSM, timeout counter, and data/grant registers.

## Test plan
- Single request: req_valid=0001, data0=0x5A.
  - req_ready=0001 for one cycle; tx_start one cycle later with tx_data=0x5A.
  - tx_busy 2 cycles later, then tx_done: active drops, grant_id=0.
- Fairness: all four valid continuously with data 0x10..0x13. Grant order is 0,1,2,3,0 and tx_data follows 0x10,0x11,0x12,0x13,0x10.
- Wrap and skip: rr_ptr=3, req_valid=0101. Grant goes to 0, then 2, then 0.
- Timeout: accept a byte and hold tx_busy=0.
  - err_timeout pulses exactly START_TIMEOUT cycles after tx_start; state returns to IDLE.
  - The next grant goes to grant_id+1.
- Reset mid-frame: assert reset for one cycle during WAIT_DONE.
  - All outputs take reset values next edge; rr_ptr=0; no err_timeout.
  - A request valid after reset is granted normally.
- Early done: tx_done and tx_busy high in the same WAIT_BUSY cycle. Completion occurs and IDLE is reached on the next edge.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Brief   : Shared UART types and constants for the TX scheduler and RX side.
// Rev     : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_START_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } sched_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first request at or above ptr, wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_idx,
   output logic                    any_req
);

   localparam int IDX_W = $clog2(NREQ);
   localparam logic [IDX_W:0] c_nreq = (IDX_W+1)'(NREQ);

   logic [IDX_W:0] w_pos;

   // Scan offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      w_pos     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (w_pos >= c_nreq) begin
            w_pos = w_pos - c_nreq;
         end
         if (req[w_pos[IDX_W-1:0]]) begin
            grant_idx = w_pos[IDX_W-1:0];
            any_req   = 1'b1;
         end
      end
      if (any_req) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Round-robin sharing of one UART transmitter among NREQ byte sources.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int DATA_W        = UART_DATA_W,
   parameter int START_TIMEOUT = UART_START_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DATA_W-1:0]  req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   input  logic                    tx_done,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    active,
   output logic                    err_timeout
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(START_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NREQ - 1);

   sched_state_t      r_state;
   sched_state_t      w_state_next;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [IDX_W-1:0]  w_rr_ptr_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [NREQ-1:0]   w_grant_oh;
   logic [IDX_W-1:0]  w_grant_idx;
   logic              w_any_req;
   logic              w_accept;
   logic              w_finish;
   logic [DATA_W-1:0] w_bytes [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req       (req_valid),
      .ptr       (r_rr_ptr),
      .grant     (w_grant_oh),
      .grant_idx (w_grant_idx),
      .any_req   (w_any_req)
   );

   assign w_rr_ptr_next = (grant_id == c_idx_last) ? '0 : grant_id + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Handshake strobes are suppressed while reset is asserted so nothing is
   // accepted or launched in the reset cycle itself.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_finish     = 1'b0;
      tx_start     = 1'b0;
      err_timeout  = 1'b0;
      req_ready    = '0;
      if (!reset) begin
         case (r_state)
            IDLE: begin
               req_ready = w_grant_oh;
               if (w_any_req) begin
                  w_accept     = 1'b1;
                  w_state_next = START;
               end
            end
            START: begin
               tx_start     = 1'b1;
               w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_done) begin
                  w_finish     = 1'b1;
                  w_state_next = IDLE;
               end else if (tx_busy) begin
                  w_state_next = WAIT_DONE;
               end else if (r_cnt == c_cnt_last) begin
                  err_timeout  = 1'b1;
                  w_finish     = 1'b1;
                  w_state_next = IDLE;
               end
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  w_finish     = 1'b1;
                  w_state_next = IDLE;
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         tx_data  <= '0;
         grant_id <= '0;
         active   <= 1'b0;
      end else begin
         if (w_accept) begin
            tx_data  <= w_bytes[w_grant_idx];
            grant_id <= w_grant_idx;
            active   <= 1'b1;
         end
         if (r_state == START) begin
            r_cnt <= '0;
         end else if (r_state == WAIT_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         // Completion and abort both advance the pointer past the served requester.
         if (w_finish) begin
            r_rr_ptr <= w_rr_ptr_next;
            active   <= 1'b0;
         end
      end
   end

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_scheduler
// Brief  : Self-checking bench with a transaction-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

   localparam int NREQ = 4;
   localparam int ST   = 64;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        active;
   logic        err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a transaction is "owned" from acceptance; its age counts
   // cycles since acceptance (age 1 is the launch cycle).
   bit         m_known = 0;
   int         m_owner = -1;
   int         m_age   = 0;
   bit         m_seen  = 0;
   int         m_ptr   = 0;
   logic [7:0] m_data  = 0;
   int         m_gid   = 0;
   bit         m_active = 0;

   int         exp_g [5] = '{0, 1, 2, 3, 0};
   logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
   int         wrap_g [3] = '{0, 2, 0};

   uart_tx_scheduler #(
      .NREQ          (NREQ),
      .DATA_W        (8),
      .START_TIMEOUT (ST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .active      (active),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int winner(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic compare_all();
      logic [3:0] e_ready;
      bit         e_start;
      bit         e_err;
      int         w;
      if (!m_known) return;
      e_ready = '0;
      e_start = 0;
      e_err   = 0;
      if (!reset) begin
         if (m_owner < 0) begin
            w = winner(req_valid, m_ptr);
            if (w >= 0) e_ready[w] = 1'b1;
         end else begin
            e_start = (m_age == 1);
            e_err   = (m_age == ST + 1) && !m_seen && !tx_done && !tx_busy;
         end
      end
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_tx_start", 32'(tx_start), 32'(e_start));
      chk("m_err_timeout", 32'(err_timeout), 32'(e_err));
      chk("m_tx_data", 32'(tx_data), 32'(m_data));
      chk("m_grant_id", 32'(grant_id), 32'(m_gid));
      chk("m_active", 32'(active), 32'(m_active));
   endtask

   task automatic model_update();
      int w;
      bit fin;
      if (reset) begin
         m_known  = 1;
         m_owner  = -1;
         m_ptr    = 0;
         m_data   = 0;
         m_gid    = 0;
         m_active = 0;
         m_age    = 0;
         m_seen   = 0;
      end else if (m_known) begin
         if (m_owner < 0) begin
            w = winner(req_valid, m_ptr);
            if (w >= 0) begin
               m_owner  = w;
               m_data   = req_data[w*8 +: 8];
               m_gid    = w;
               m_active = 1;
               m_age    = 1;
               m_seen   = 0;
            end
         end else begin
            fin = 0;
            if (m_age >= 2) begin
               if (tx_done) fin = 1;
               else if (!m_seen && tx_busy) m_seen = 1;
               else if (!m_seen && m_age == ST + 1) fin = 1;
            end
            m_age++;
            if (fin) begin
               m_owner  = -1;
               m_active = 0;
               m_ptr    = (m_gid + 1) % NREQ;
            end
         end
      end
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic tick();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic wait_start(output bit ok);
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (tx_start) begin
            ok = 1;
            break;
         end
         tick();
      end
      ok = tx_start;
   endtask

   task automatic serve(input logic [3:0] v, input int gap, input int len, input bit early,
                        output int gid, output logic [7:0] data);
      bit ok;
      req_valid = v;
      wait_start(ok);
      chk("serve_start_seen", 32'(ok), 32'd1);
      gid  = int'(grant_id);
      data = tx_data;
      if (!ok) return;
      req_valid = '0;
      tick();
      repeat (gap) tick();
      if (early) begin
         tx_busy = 1'b1;
         tx_done = 1'b1;
         tick();
      end else begin
         tx_busy = 1'b1;
         repeat (len) tick();
         tx_done = 1'b1;
         tick();
      end
      tx_busy = 1'b0;
      tx_done = 1'b0;
   endtask

   task automatic reset_dut();
      reset     = 1'b1;
      req_valid = '0;
      tx_busy   = 1'b0;
      tx_done   = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int         g;
      int         cyc;
      bit         ok;
      logic [7:0] d;

      reset     = 1'b1;
      req_valid = 4'b1111;
      req_data  = 32'h13121110;
      tx_busy   = 1'b0;
      tx_done   = 1'b0;
      #1;
      chk("reset_ready_gated", 32'(req_ready), 32'd0);
      tick();
      tick();
      chk("reset_tx_data", 32'(tx_data), 32'd0);
      chk("reset_grant_id", 32'(grant_id), 32'd0);
      chk("reset_active", 32'(active), 32'd0);
      chk("reset_tx_start", 32'(tx_start), 32'd0);
      req_valid = '0;
      reset     = 1'b0;
      tick();

      // Single request
      req_data[7:0] = 8'h5A;
      req_valid     = 4'b0001;
      #1;
      chk("single_ready", 32'(req_ready), 32'b0001);
      serve(4'b0001, 1, 3, 0, g, d);
      chk("single_gid", 32'(g), 32'd0);
      chk("single_data", 32'(d), 32'h5A);
      chk("single_active_drop", 32'(active), 32'd0);
      chk("single_gid_after", 32'(grant_id), 32'd0);

      // Fairness
      reset_dut();
      req_data = 32'h13121110;
      for (int i = 0; i < 5; i++) begin
         serve(4'b1111, 1, 3, 0, g, d);
         chk("fair_gid", 32'(g), 32'(exp_g[i]));
         chk("fair_data", 32'(d), 32'(exp_d[i]));
      end

      // Wrap and skip: serving requester 2 leaves the pointer at 3
      reset_dut();
      serve(4'b0100, 0, 2, 0, g, d);
      chk("wrap_setup_gid", 32'(g), 32'd2);
      for (int i = 0; i < 3; i++) begin
         serve(4'b0101, 0, 2, 0, g, d);
         chk("wrap_gid", 32'(g), 32'(wrap_g[i]));
      end

      // Timeout
      reset_dut();
      req_valid = 4'b0010;
      wait_start(ok);
      chk("to_start_seen", 32'(ok), 32'd1);
      req_valid = '0;
      cyc = -1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (err_timeout) begin
            cyc = k;
            break;
         end
      end
      chk("to_cycles_after_start", 32'(cyc), 32'(ST));
      chk("to_gid", 32'(grant_id), 32'd1);
      tick();
      chk("to_active_drop", 32'(active), 32'd0);
      chk("to_err_one_cycle", 32'(err_timeout), 32'd0);
      serve(4'b1111, 0, 2, 0, g, d);
      chk("to_next_gid", 32'(g), 32'd2);

      // Reset mid-frame (pointer is 3 here)
      req_valid = 4'b0010;
      wait_start(ok);
      chk("mid_start_seen", 32'(ok), 32'd1);
      chk("mid_gid", 32'(grant_id), 32'd1);
      req_valid = '0;
      tick();
      tx_busy = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      tx_busy = 1'b0;
      chk("mid_active", 32'(active), 32'd0);
      chk("mid_grant_id", 32'(grant_id), 32'd0);
      chk("mid_tx_data", 32'(tx_data), 32'd0);
      chk("mid_err", 32'(err_timeout), 32'd0);
      serve(4'b1100, 0, 2, 0, g, d);
      chk("mid_after_gid", 32'(g), 32'd2);

      // Early done: busy and done together in the first wait cycle
      serve(4'b0001, 0, 0, 1, g, d);
      chk("early_gid", 32'(g), 32'd0);
      chk("early_active", 32'(active), 32'd0);
      chk("early_start", 32'(tx_start), 32'd0);
      req_valid = 4'b1000;
      #1;
      chk("early_idle_ready", 32'(req_ready), 32'b1000);
      tick();
      req_valid = '0;
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_tx_scheduler
`default_nettype wire
